// File: rtl/mux_sel_arbiter_2ch_pkg.sv
// rtl/mux_sel_arbiter_2ch_pkg.sv - shared encodings for the 2-channel mux select arbiter
//
// Holds the FSM state encoding, the mux select encoding (also used by anything
// driving the mux en pin) and the round-robin grant helper.
package mux_sel_arbiter_2ch_pkg;

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  // mux en convention: 0 selects operand a, 1 selects operand b
  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  typedef enum logic {
    S_EMPTY = ST_EMPTY,
    S_FULL  = ST_FULL
  } state_t;

  // Returns {grant_b, grant_a}. prio names the channel that wins a tie.
  // A lone requester always wins, regardless of prio.
  function automatic logic [1:0] rr_grant(input logic a_valid,
                                          input logic b_valid,
                                          input logic prio);
    logic ga;
    logic gb;
    ga = a_valid & (~b_valid | (prio == SEL_A));
    gb = b_valid & (~a_valid | (prio == SEL_B));
    return {gb, ga};
  endfunction

endpackage

// File: rtl/mux_sel_arbiter_2ch_sat_counter.sv
// rtl/mux_sel_arbiter_2ch_sat_counter.sv - saturating up-counter used for per-channel grant counts
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset, clears count
//   inc    in   1      add one this cycle unless already at all-ones
//   count  out  WIDTH  current count; sticks at 2**WIDTH-1
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {WIDTH{1'b1}})) begin
      count <= count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/mux_sel_arbiter_2ch.sv
// rtl/mux_sel_arbiter_2ch.sv - round-robin 2-channel arbiter feeding a 4-bit 2:1 mux
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   a_data     in   WIDTH  channel A word
//   a_valid    in   1      channel A word present
//   a_ready    out  1      channel A accepted this cycle (combinational)
//   b_data     in   WIDTH  channel B word
//   b_valid    in   1      channel B word present
//   b_ready    out  1      channel B accepted this cycle (combinational)
//   mux_a      out  WIDTH  registered operand for mux input a
//   mux_b      out  WIDTH  registered operand for mux input b
//   mux_sel    out  1      registered mux select (0=A, 1=B)
//   out_valid  out  1      mux output holds a granted word
//   out_ready  in   1      downstream consumes the mux output this cycle
//   cnt_a      out  CNT_W  saturating count of A grants
//   cnt_b      out  CNT_W  saturating count of B grants
module mux_sel_arbiter_2ch
  import mux_sel_arbiter_2ch_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  output logic             b_ready,
  output logic [WIDTH-1:0] mux_a,
  output logic [WIDTH-1:0] mux_b,
  output logic             mux_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b
);

  state_t     state;
  logic       prio;
  logic       load;
  logic [1:0] grant;

  // The holding register may take a new word when empty, or when the word it
  // holds leaves this cycle.
  assign load  = (state == S_EMPTY) | out_ready;
  assign grant = rr_grant(a_valid, b_valid, prio);

  // Readies are gated by rst_n so nothing handshakes while reset is held.
  assign a_ready = rst_n & load & grant[0];
  assign b_ready = rst_n & load & grant[1];

  assign out_valid = (state == S_FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_EMPTY;
      mux_a   <= '0;
      mux_b   <= '0;
      mux_sel <= SEL_A;
      prio    <= SEL_A;
    end else if (load) begin
      if (grant[0]) begin
        mux_a   <= a_data;
        mux_sel <= SEL_A;
        prio    <= SEL_B;
        state   <= S_FULL;
      end else if (grant[1]) begin
        mux_b   <= b_data;
        mux_sel <= SEL_B;
        prio    <= SEL_A;
        state   <= S_FULL;
      end else begin
        // Held word consumed (or nothing held) and no requester: go idle.
        // prio is untouched so the next contention still honours it.
        state <= S_EMPTY;
      end
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_cnt_a (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (a_ready),
    .count (cnt_a)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_b (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (b_ready),
    .count (cnt_b)
  );

endmodule
